// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-set controller: hour/minute edit sequencing, shadow time, commit load
module clock_set_ctrl #(
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hour_tens,
    input  logic [3:0] cur_hour_units,
    input  logic [3:0] cur_min_tens,
    input  logic [3:0] cur_min_units,
    input  logic       cur_is_am,
    output logic       run_en,
    output logic       load,
    output logic [3:0] ld_hour_tens,
    output logic [3:0] ld_hour_units,
    output logic [3:0] ld_min_tens,
    output logic [3:0] ld_min_units,
    output logic       ld_is_am,
    output logic       blank_hour,
    output logic       blank_min,
    output logic       editing
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    state_t     state;
    state_t     nxt_state;
    logic [7:0] idle_cnt;
    logic [7:0] nxt_idle;
    logic       phase;
    logic       nxt_phase;
    logic       capture;
    logic       do_hour_inc;
    logic       do_min_inc;

    // The ld_* outputs double as the shadow registers, so they always show the edited copy.
    logic [3:0] hinc_tens;
    logic [3:0] hinc_units;
    logic       hinc_am_flip;
    logic [3:0] minc_tens;
    logic [3:0] minc_units;
    logic       cur_hour_ok;
    logic       cur_min_ok;

    // Shadow hour step 01..12 with AM/PM flip on 11->12, minute step 00..59 without carry.
    always_comb begin
        hinc_tens    = ld_hour_tens;
        hinc_units   = ld_hour_units + 4'd1;
        hinc_am_flip = 1'b0;
        if (ld_hour_tens == 4'd1 && ld_hour_units == 4'd2) begin
            hinc_tens  = 4'd0;
            hinc_units = 4'd1;
        end else if (ld_hour_tens == 4'd1 && ld_hour_units == 4'd1) begin
            hinc_am_flip = 1'b1;
        end else if (ld_hour_units == 4'd9) begin
            hinc_tens  = 4'd1;
            hinc_units = 4'd0;
        end

        minc_tens  = ld_min_tens;
        minc_units = ld_min_units + 4'd1;
        if (ld_min_units == 4'd9) begin
            minc_units = 4'd0;
            minc_tens  = (ld_min_tens == 4'd5) ? 4'd0 : ld_min_tens + 4'd1;
        end

        cur_hour_ok = (cur_hour_units <= 4'd9) &&
                      ((cur_hour_tens == 4'd0 && cur_hour_units != 4'd0) ||
                       (cur_hour_tens == 4'd1 && cur_hour_units <= 4'd2));
        cur_min_ok  = (cur_min_tens <= 4'd5) && (cur_min_units <= 4'd9);
    end

    // Next-state decode: mode beats inc, any button beats the idle timeout.
    always_comb begin
        nxt_state   = state;
        nxt_idle    = idle_cnt;
        nxt_phase   = phase;
        capture     = 1'b0;
        do_hour_inc = 1'b0;
        do_min_inc  = 1'b0;
        case (state)
            RUN: begin
                if (btn_mode) begin
                    nxt_state = SET_HOUR;
                    capture   = 1'b1;
                    nxt_idle  = 8'd0;
                    nxt_phase = 1'b0;
                end
            end
            SET_HOUR, SET_MIN: begin
                if (btn_mode) begin
                    nxt_state = (state == SET_HOUR) ? SET_MIN : COMMIT;
                    nxt_idle  = 8'd0;
                    if (tick_1hz) begin
                        nxt_phase = ~phase;
                    end
                end else if (btn_inc) begin
                    do_hour_inc = (state == SET_HOUR);
                    do_min_inc  = (state == SET_MIN);
                    nxt_idle    = 8'd0;
                    nxt_phase   = 1'b0;
                end else if (tick_1hz) begin
                    if (idle_cnt == 8'(TIMEOUT_S - 1)) begin
                        nxt_state = RUN;
                        nxt_idle  = 8'd0;
                        nxt_phase = 1'b0;
                    end else begin
                        nxt_idle  = idle_cnt + 8'd1;
                        nxt_phase = ~phase;
                    end
                end
            end
            COMMIT: begin
                nxt_state = RUN;
            end
            default: begin
                nxt_state = RUN;
            end
        endcase
    end

    // State, shadow time and all control outputs registered from the decoded next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            idle_cnt      <= 8'd0;
            phase         <= 1'b0;
            ld_hour_tens  <= 4'd1;
            ld_hour_units <= 4'd2;
            ld_min_tens   <= 4'd0;
            ld_min_units  <= 4'd0;
            ld_is_am      <= 1'b1;
            run_en        <= 1'b1;
            load          <= 1'b0;
            editing       <= 1'b0;
            blank_hour    <= 1'b0;
            blank_min     <= 1'b0;
        end else begin
            state    <= nxt_state;
            idle_cnt <= nxt_idle;
            phase    <= nxt_phase;
            if (capture) begin
                if (cur_hour_ok) begin
                    ld_hour_tens  <= cur_hour_tens;
                    ld_hour_units <= cur_hour_units;
                    ld_is_am      <= cur_is_am;
                end else begin
                    ld_hour_tens  <= 4'd1;
                    ld_hour_units <= 4'd2;
                    ld_is_am      <= 1'b1;
                end
                ld_min_tens  <= cur_min_ok ? cur_min_tens  : 4'd0;
                ld_min_units <= cur_min_ok ? cur_min_units : 4'd0;
            end else if (do_hour_inc) begin
                ld_hour_tens  <= hinc_tens;
                ld_hour_units <= hinc_units;
                ld_is_am      <= ld_is_am ^ hinc_am_flip;
            end else if (do_min_inc) begin
                ld_min_tens  <= minc_tens;
                ld_min_units <= minc_units;
            end
            run_en     <= (nxt_state == RUN);
            load       <= (nxt_state == COMMIT);
            editing    <= (nxt_state == SET_HOUR) || (nxt_state == SET_MIN);
            blank_hour <= (nxt_state == SET_HOUR) && nxt_phase;
            blank_min  <= (nxt_state == SET_MIN) && nxt_phase;
        end
    end

endmodule
